// File: rtl/instr_encoder_if.sv
// Operation-in / instruction-memory-write-out bundle for instr_encoder.
// No logic of its own; latency belongs to the encoder.
// Backpressure: producer holds in_valid until in_ready; the memory side takes no backpressure.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              finish;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err_illegal;

    modport master (
        output in_valid, op_sel, rd, rs, rt, imm, target, finish,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err_illegal
    );

    modport slave (
        input  in_valid, op_sel, rd, rs, rt, imm, target, finish,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err_illegal
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes symbolic ops into 32-bit instructions and loads them at sequential addresses; pads with NOPs on finish.
// Latency: write strobe one cycle after the accepting edge; one op per two cycles.
// Backpressure: in_ready low outside IDLE, when full, or once finish is pending.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    instr_encoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              pend_q, pend_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              in_ready;
    logic              xfer;
    logic              legal;

    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        w = 32'd0;
        case (op)
            4'd0: w = {6'd12, rs, rt, rd, 5'd0, 6'd32};
            4'd1: w = {6'd12, rs, rt, rd, 5'd0, 6'd34};
            4'd2: w = {6'd12, rs, rt, rd, 5'd0, 6'd50};
            4'd3: w = {6'd34, rs, rd, imm};
            4'd4: w = {6'd35, rs, rt, imm};
            4'd5: w = {6'd36, rs, rt, imm};
            4'd6: w = {6'd37, rs, rd, imm};
            4'd7: w = {6'd38, rs, rd, imm};
            4'd8: w = {6'd2, target};
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    assign in_ready = (state_q == IDLE) && !full_q && !pend_q;
    assign xfer     = bus.in_valid && in_ready;
    assign legal    = (bus.op_sel <= 4'd8);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pend_d      = pend_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        full_d      = full_q;
        done_d      = done_q;
        err_d       = err_q;

        if (bus.finish && (state_q == IDLE || state_q == WRITE))
            pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (legal) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = encode(bus.op_sel, bus.rd, bus.rs, bus.rt, bus.imm, bus.target);
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (pend_q) begin
                    if (full_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d     = FILL;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = count_q[ADDR_W-1:0];
                        mem_wdata_d = 32'd0;
                    end
                end
            end
            WRITE: begin
                count_d = count_q + 1'b1;
                full_d  = (count_d == DEPTH_C);
                if (!pend_q) begin
                    state_d = IDLE;
                end else if (count_d == DEPTH_C) begin
                    // Last slot just taken by the instruction: nothing left to pad.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d     = FILL;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_d[ADDR_W-1:0];
                    mem_wdata_d = 32'd0;
                end
            end
            FILL: begin
                count_d = count_q + 1'b1;
                full_d  = (count_d == DEPTH_C);
                if (count_d == DEPTH_C) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = count_d[ADDR_W-1:0];
                    mem_wdata_d = 32'd0;
                end
            end
            DONE: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pend_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            full_q      <= full_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.count       = count_q;
    assign bus.full        = full_q;
    assign bus.done        = done_q;
    assign bus.err_illegal = err_q;
endmodule
